// File: rtl/dm_responder.sv
// Data-memory responder for the MIPS core's M-stage data port: combinational
// word reads, byte-enable-merged writes and a buffered store-trace stream.
module dm_responder #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned FIFO_LOG2  = 3,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic [3:0]  trace_byteen,
    output logic [31:0] store_count,
    output logic        overflow,
    output logic        addr_err
);
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned FDEPTH = 1 << FIFO_LOG2;
    localparam int unsigned PW     = FIFO_LOG2 + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  byteen;
    } trace_t;

    logic [31:0]           r_mem [DEPTH];
    trace_t                r_fifo [FDEPTH];
    logic [PW-1:0]         r_wp;
    logic [PW-1:0]         r_rp;
    logic [31:0]           r_store_count;
    logic                  r_overflow;
    logic                  r_addr_err;

    logic [31:0]           w_off;
    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_cur;
    logic [31:0]           w_merged;
    logic                  w_req;
    logic                  w_wr;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    trace_t                w_head;
    trace_t                w_entry;

    // Unsigned offset: addresses below base wrap high and fall out of range.
    assign w_off      = m_data_addr - BASE_ADDR;
    assign w_in_range = (w_off >> 2) < 32'(DEPTH);
    assign w_idx      = w_off[DEPTH_LOG2+1:2];
    assign w_cur      = r_mem[w_idx];
    assign w_req      = (m_data_byteen != 4'b0000);
    assign w_wr       = w_req && w_in_range;

    always_comb begin
        w_merged = w_cur;
        for (int k = 0; k < 4; k++) begin
            if (m_data_byteen[k]) w_merged[8*k +: 8] = m_data_wdata[8*k +: 8];
        end
    end

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[FIFO_LOG2-1:0] == r_rp[FIFO_LOG2-1:0]) && (r_wp[PW-1] != r_rp[PW-1]);
    assign w_pop   = !w_empty && trace_ready;
    assign w_push  = w_wr && (!w_full || w_pop);

    assign w_entry = '{pc: m_inst_addr, addr: {m_data_addr[31:2], 2'b00},
                       data: w_merged, byteen: m_data_byteen};
    assign w_head  = r_fifo[r_rp[FIFO_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (w_wr) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(FDEPTH); i++) r_fifo[i] <= '0;
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wp[FIFO_LOG2-1:0]] <= w_entry;
                r_wp <= r_wp + PW'(1);
            end
            if (w_pop) r_rp <= r_rp + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_store_count <= '0;
            r_overflow    <= 1'b0;
            r_addr_err    <= 1'b0;
        end else begin
            if (w_wr) r_store_count <= r_store_count + 32'd1;
            if (w_wr && !w_push) r_overflow <= 1'b1;
            if (!w_in_range) r_addr_err <= 1'b1;
        end
    end

    assign m_data_rdata = w_in_range ? w_cur : 32'h0;
    assign trace_valid  = !w_empty;
    assign trace_pc     = w_head.pc;
    assign trace_addr   = w_head.addr;
    assign trace_data   = w_head.data;
    assign trace_byteen = w_head.byteen;
    assign store_count  = r_store_count;
    assign overflow     = r_overflow;
    assign addr_err     = r_addr_err;

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder: readback, byte merge,
// backpressure/overflow, simultaneous push/pop, out-of-range and mid-run reset.
module tb_dm_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  trace_byteen;
    logic [31:0] store_count;
    logic        overflow;
    logic        addr_err;

    int n_total = 0;
    int n_bad   = 0;

    dm_responder #(.DEPTH_LOG2(12), .FIFO_LOG2(3), .BASE_ADDR(32'h0000_0000)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .m_data_addr  (m_data_addr),
        .m_data_wdata (m_data_wdata),
        .m_data_byteen(m_data_byteen),
        .m_inst_addr  (m_inst_addr),
        .m_data_rdata (m_data_rdata),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_pc     (trace_pc),
        .trace_addr   (trace_addr),
        .trace_data   (trace_data),
        .trace_byteen (trace_byteen),
        .store_count  (store_count),
        .overflow     (overflow),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Present a request at a falling edge; returns at the next falling edge.
    task automatic cyc(input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input logic [31:0] pc);
        m_data_addr   = addr;
        m_data_wdata  = data;
        m_data_byteen = be;
        m_inst_addr   = pc;
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] addr);
        m_data_addr   = addr;
        m_data_byteen = 4'b0000;
        #1;
    endtask

    initial begin
        reset = 1'b1; trace_ready = 1'b0;
        m_data_addr = '0; m_data_wdata = '0; m_data_byteen = '0; m_inst_addr = '0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        rd(32'h10);
        chk("rst_rdata", m_data_rdata, 32'h0);
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk("rst_pc", trace_pc, 32'h0);
        chk("rst_count", store_count, 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_aerr", 32'(addr_err), 32'd0);

        cyc(32'h10, 32'hDEADBEEF, 4'b1111, 32'h3000);
        rd(32'h10);
        chk("word_rd", m_data_rdata, 32'hDEADBEEF);
        chk("word_valid", 32'(trace_valid), 32'd1);
        chk("word_tpc", trace_pc, 32'h3000);
        chk("word_taddr", trace_addr, 32'h10);
        chk("word_tdata", trace_data, 32'hDEADBEEF);
        chk("word_tbe", 32'(trace_byteen), 32'hF);
        chk("word_count", store_count, 32'd1);

        // Byte merge; read in the write cycle still shows the old word.
        m_data_addr = 32'h13; m_data_wdata = 32'h11223344; m_data_byteen = 4'b1000;
        m_inst_addr = 32'h3004;
        #1;
        chk("prewrite_rd", m_data_rdata, 32'hDEADBEEF);
        @(negedge clk);
        rd(32'h10);
        chk("byte_rd", m_data_rdata, 32'h11ADBEEF);
        trace_ready = 1'b1;
        @(negedge clk);
        trace_ready = 1'b0;
        #1;
        chk("byte_tdata", trace_data, 32'h11ADBEEF);
        chk("byte_taddr", trace_addr, 32'h10);
        chk("byte_tbe", 32'(trace_byteen), 32'h8);

        cyc(32'h10, 32'h0000CAFE, 4'b0011, 32'h3008);
        rd(32'h10);
        chk("half_rd", m_data_rdata, 32'h11ADCAFE);
        chk("half_count", store_count, 32'd3);
        trace_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        trace_ready = 1'b0;
        #1;
        chk("drain1_valid", 32'(trace_valid), 32'd0);

        // Fill to full, then a write while popping keeps occupancy at 8.
        for (int i = 0; i < 8; i++) cyc(32'h200 + 32'(4*i), 32'hB000_0000 + 32'(i), 4'b1111, 32'h5000 + 32'(4*i));
        trace_ready = 1'b1;
        cyc(32'h220, 32'hB000_0008, 4'b1111, 32'h5020);
        m_data_byteen = 4'b0000;
        #1;
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_count", store_count, 32'd12);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("pp_pc%0d", i), trace_pc, 32'h5000 + 32'(4*i));
            chk($sformatf("pp_val%0d", i), 32'(trace_valid), 32'd1);
            @(negedge clk);
            #1;
        end
        chk("pp_empty", 32'(trace_valid), 32'd0);

        // Backpressure: nine writes into an empty FIFO with ready low.
        trace_ready = 1'b0;
        for (int i = 0; i < 9; i++) cyc(32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'b1111, 32'h4000 + 32'(4*i));
        rd(32'h120);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_mem9", m_data_rdata, 32'hA000_0008);
        chk("ovf_count", store_count, 32'd21);
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_pc%0d", i), trace_pc, 32'h4000 + 32'(4*i));
            chk($sformatf("ovf_data%0d", i), trace_data, 32'hA000_0000 + 32'(i));
            @(negedge clk);
            #1;
        end
        chk("ovf_empty", 32'(trace_valid), 32'd0);
        trace_ready = 1'b0;

        // Range boundary and out-of-range write.
        chk("aerr_before", 32'(addr_err), 32'd0);
        cyc(32'h3FFC, 32'h0000_0055, 4'b1111, 32'h6000);
        rd(32'h3FFC);
        chk("top_word_rd", m_data_rdata, 32'h55);
        chk("top_aerr", 32'(addr_err), 32'd0);
        trace_ready = 1'b1;
        @(negedge clk);
        trace_ready = 1'b0;
        cyc(32'h4000, 32'h1234_5678, 4'b1111, 32'h6004);
        rd(32'h4000);
        chk("oor_rd", m_data_rdata, 32'h0);
        chk("oor_aerr", 32'(addr_err), 32'd1);
        chk("oor_count", store_count, 32'd22);
        chk("oor_valid", 32'(trace_valid), 32'd0);
        rd(32'h0);
        chk("oor_alias", m_data_rdata, 32'h0);

        // Reset with three entries queued and a write presented.
        for (int i = 0; i < 3; i++) cyc(32'h20 + 32'(4*i), 32'hC000_0000 + 32'(i), 4'b1111, 32'h7000);
        reset = 1'b1;
        cyc(32'h40, 32'h0000_0077, 4'b1111, 32'h7010);
        reset = 1'b0;
        rd(32'h40);
        chk("mr_rd_wr", m_data_rdata, 32'h0);
        chk("mr_valid", 32'(trace_valid), 32'd0);
        chk("mr_tdata", trace_data, 32'h0);
        chk("mr_tpc", trace_pc, 32'h0);
        chk("mr_count", store_count, 32'd0);
        chk("mr_ovf", 32'(overflow), 32'd0);
        chk("mr_aerr", 32'(addr_err), 32'd0);
        rd(32'h20);
        chk("mr_rd_old", m_data_rdata, 32'h0);
        rd(32'h10);
        chk("mr_rd_10", m_data_rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
